// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter for the async FIFO write port.
// A winner keeps the port until its last beat or MAX_BURST beats.
module fifo_write_arbiter #(
    parameter int DATASIZE   = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    parameter int AFULL_GATE = 1
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATASIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATASIZE-1:0]           wdata,
    output logic                          winc,
    input  logic                          wfull,
    input  logic                          walmost_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q, last_d;
    logic [BW-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  gsel;
    logic                vld_g;
    logic                lst_g;
    logic                can_grant;
    logic                cap;
    logic [NUM_REQ-1:0]  rot;
    logic [GW-1:0]       off;
    logic [GW:0]         sum;
    logic [GW-1:0]       winner;
    logic [DATASIZE-1:0] slice;

    assign gsel  = NUM_REQ'(1) << grant_q;
    assign vld_g = |(req_valid & gsel);
    assign lst_g = |(req_last & gsel);

    assign busy      = (state_q == S_BURST);
    // Live wfull gates winc so no beat ever reaches a full FIFO
    assign winc      = busy & vld_g & ~wfull;
    assign req_ready = winc ? gsel : '0;
    assign grant_id  = grant_q;

    always_comb begin
        slice = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) slice = req_data[i*DATASIZE +: DATASIZE];
        end
    end

    assign wdata = busy ? slice : '0;

    // Rotate so bit 0 is the requester right after the last winner
    assign rot = NUM_REQ'({req_valid, req_valid} >>
                          ((GW+1)'(last_q) + (GW+1)'(1)));

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = GW'(k);
        end
    end

    assign sum    = (GW+1)'(last_q) + (GW+1)'(off) + (GW+1)'(1);
    assign winner = (sum >= (GW+1)'(NUM_REQ))
                  ? GW'(sum - (GW+1)'(NUM_REQ)) : GW'(sum);

    assign can_grant = (|req_valid) & ~wfull &
                       ((AFULL_GATE == 0) | ~walmost_full);
    assign cap       = (cnt_q == BW'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (winc) begin
                    if (lst_g | cap) begin
                        state_d = S_IDLE;
                        last_d  = grant_q;
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_fifo_write_arbiter;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req_valid, req_last;
    logic [31:0] req_data;
    logic        wfull, walmost_full;

    logic [3:0]  req_ready, req_ready0;
    logic [7:0]  wdata, wdata0;
    logic        winc, winc0;
    logic [1:0]  grant_id, grant_id0;
    logic        busy, busy0;

    int tests = 0;
    int fails = 0;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(
        .DATASIZE(8), .NUM_REQ(4), .MAX_BURST(4), .AFULL_GATE(1)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .wdata(wdata), .winc(winc),
        .wfull(wfull), .walmost_full(walmost_full),
        .grant_id(grant_id), .busy(busy)
    );

    fifo_write_arbiter #(
        .DATASIZE(8), .NUM_REQ(4), .MAX_BURST(4), .AFULL_GATE(0)
    ) dut0 (
        .wclk(wclk), .wrst_n(wrst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready0), .wdata(wdata0), .winc(winc0),
        .wfull(wfull), .walmost_full(walmost_full),
        .grant_id(grant_id0), .busy(busy0)
    );

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        f;
        logic        af;
        logic        ew;
        logic [3:0]  er;
        logic [7:0]  ed;
        logic        eb;
        logic [1:0]  eg;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic f,
                         input logic af);
        req_valid    = v;
        req_last     = l;
        req_data     = d;
        wfull        = f;
        walmost_full = af;
    endtask

    task automatic do_reset();
        drive(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        wrst_n = 1'b0;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        check("rst_winc", winc, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_wdata", wdata, 0);
        check("rst_gid", grant_id, 0);
        wrst_n = 1'b1;
    endtask

    function automatic int first_from(input int p, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[2'((p + k) % 4)]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        int q[$];
        logic [7:0] got[$];
        int n, wr, acc;
        logic [7:0] exp_cap[7];
        logic [3:0] vld, lst;
        logic [7:0] seq[4];
        logic [7:0] dat[4];
        int owner, plast, gid, taken;
        logic f, af, ew, eb;
        logic [3:0] er;
        logic [7:0] ed;
        int rst_seen;

        tbl[0]  = '{4'b0001, 4'b0000, 32'h0000_0010, 0, 0, 0, 4'b0000, 8'h00, 0, 2'd0};
        tbl[1]  = '{4'b0001, 4'b0000, 32'h0000_0010, 0, 0, 1, 4'b0001, 8'h10, 1, 2'd0};
        tbl[2]  = '{4'b0001, 4'b0000, 32'h0000_0011, 0, 0, 1, 4'b0001, 8'h11, 1, 2'd0};
        tbl[3]  = '{4'b0001, 4'b0001, 32'h0000_0012, 0, 0, 1, 4'b0001, 8'h12, 1, 2'd0};
        tbl[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 8'h00, 0, 2'd0};
        tbl[5]  = '{4'b0011, 4'b0011, 32'h0000_2013, 0, 0, 0, 4'b0000, 8'h00, 0, 2'd0};
        tbl[6]  = '{4'b0011, 4'b0011, 32'h0000_2013, 0, 0, 1, 4'b0010, 8'h20, 1, 2'd1};
        tbl[7]  = '{4'b0001, 4'b0001, 32'h0000_2013, 0, 0, 0, 4'b0000, 8'h00, 0, 2'd1};
        tbl[8]  = '{4'b0001, 4'b0001, 32'h0000_2013, 0, 0, 1, 4'b0001, 8'h13, 1, 2'd0};
        tbl[9]  = '{4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 8'h00, 0, 2'd0};
        tbl[10] = '{4'b0100, 4'b0000, 32'h0030_0000, 0, 1, 0, 4'b0000, 8'h00, 0, 2'd0};
        tbl[11] = '{4'b0100, 4'b0000, 32'h0030_0000, 0, 0, 0, 4'b0000, 8'h00, 0, 2'd0};
        tbl[12] = '{4'b0100, 4'b0000, 32'h0030_0000, 0, 1, 1, 4'b0100, 8'h30, 1, 2'd2};
        tbl[13] = '{4'b0100, 4'b0000, 32'h0031_0000, 1, 0, 0, 4'b0000, 8'h31, 1, 2'd2};
        tbl[14] = '{4'b0100, 4'b0000, 32'h0031_0000, 1, 0, 0, 4'b0000, 8'h31, 1, 2'd2};
        tbl[15] = '{4'b0100, 4'b0000, 32'h0031_0000, 0, 0, 1, 4'b0100, 8'h31, 1, 2'd2};
        tbl[16] = '{4'b0000, 4'b0000, 32'h0032_0000, 0, 0, 0, 4'b0000, 8'h32, 1, 2'd2};
        tbl[17] = '{4'b0100, 4'b0000, 32'h0032_0000, 0, 0, 1, 4'b0100, 8'h32, 1, 2'd2};
        tbl[18] = '{4'b0100, 4'b0000, 32'h0033_0000, 0, 0, 1, 4'b0100, 8'h33, 1, 2'd2};
        tbl[19] = '{4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 8'h00, 0, 2'd2};

        // Vector table: packet of 3, priority rotation, gating, stalls
        do_reset();
        for (int r = 0; r < 20; r++) begin
            drive(tbl[r].v, tbl[r].l, tbl[r].d, tbl[r].f, tbl[r].af);
            #2;
            check($sformatf("t%0d_winc", r), winc, tbl[r].ew);
            check($sformatf("t%0d_ready", r), req_ready, tbl[r].er);
            check($sformatf("t%0d_wdata", r), wdata, tbl[r].ed);
            check($sformatf("t%0d_busy", r), busy, tbl[r].eb);
            check($sformatf("t%0d_gid", r), grant_id, tbl[r].eg);
            @(posedge wclk);
            #1;
        end

        // Fairness: four continuous single-beat requesters
        do_reset();
        q.delete();
        drive(4'hF, 4'hF, 32'h3322_1100, 1'b0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            #2;
            check($sformatf("fair_winc%0d", c), winc, (c % 2) == 1);
            if (winc) q.push_back(int'(grant_id));
            @(posedge wclk);
            #1;
        end
        check("fair_count", q.size(), 8);
        for (int k = 0; k < q.size(); k++)
            check($sformatf("fair_order%0d", k), q[k], k % 4);

        // Burst cap: 6-beat packet from 2 with requester 3 waiting
        do_reset();
        got.delete();
        exp_cap = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h40, 8'h24, 8'h25};
        n = 0;
        vld = 4'b1100;
        for (int c = 0; c < 30 && vld != 4'b0000; c++) begin
            drive(vld, {1'b1, n == 5, 2'b00},
                  {8'h40, 8'h20 + 8'(n), 16'h0}, 1'b0, 1'b0);
            #2;
            acc = 0;
            if (winc) got.push_back(wdata);
            if (req_ready[2]) acc = 2;
            if (req_ready[3]) acc = 3;
            @(posedge wclk);
            #1;
            if (acc == 2) begin
                n++;
                if (n == 6) vld[2] = 1'b0;
            end
            if (acc == 3) vld[3] = 1'b0;
        end
        check("cap_count", got.size(), 7);
        for (int k = 0; k < 7 && k < got.size(); k++)
            check($sformatf("cap_beat%0d", k), got[k], exp_cap[k]);

        // AFULL gating, both gate settings from the same stimulus
        do_reset();
        drive(4'b0010, 4'b0010, 32'h0000_7700, 1'b0, 1'b1);
        @(posedge wclk);
        #1;
        check("afg_busy_gated", busy, 0);
        check("afg_busy_ungated", busy0, 1);
        check("afg_gid_ungated", grant_id0, 1);
        check("afg_winc_ungated", winc0, 1);
        walmost_full = 1'b0;
        @(posedge wclk);
        #1;
        check("afg_busy_after", busy, 1);
        check("afg_gid_after", grant_id, 1);

        // Asynchronous reset after beat 2 of a 4-beat packet
        do_reset();
        n = 0;
        rst_seen = 0;
        for (int c = 0; c < 20 && rst_seen == 0; c++) begin
            drive(4'b0001, {3'b000, n == 3}, 32'h50 + 32'(n), 1'b0, 1'b0);
            #2;
            acc = int'(winc);
            if (n == 2 && winc) begin
                #1 wrst_n = 1'b0;
                #1;
                check("mrst_winc", winc, 0);
                check("mrst_ready", req_ready, 0);
                check("mrst_busy", busy, 0);
                check("mrst_wdata", wdata, 0);
                rst_seen = 1;
            end else begin
                @(posedge wclk);
                #1;
                if (acc != 0) n++;
            end
        end
        check("mrst_reached", rst_seen, 1);
        wr = 0;
        repeat (2) begin
            @(negedge wclk);
            if (winc) wr++;
        end
        check("mrst_spurious", wr, 0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        drive(4'b0011, 4'b0011, 32'h0000_6150, 1'b0, 1'b0);
        #2;
        check("mrst_idle", busy, 0);
        @(posedge wclk);
        #1;
        check("mrst_gid", grant_id, 0);
        check("mrst_busy2", busy, 1);
        check("mrst_wdata2", wdata, 8'h50);
        check("mrst_ready2", req_ready, 4'b0001);

        // Randomized traffic against a packet-level model
        do_reset();
        vld = '0;
        lst = '0;
        for (int i = 0; i < 4; i++) seq[i] = '0;
        owner = -1;
        plast = 3;
        gid = 0;
        taken = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!vld[i] && $urandom_range(2) == 0) begin
                    vld[i] = 1'b1;
                    lst[i] = ($urandom_range(3) == 0);
                end
                dat[i] = {2'(i), seq[i][5:0]};
            end
            f  = ($urandom_range(4) == 0);
            af = ($urandom_range(4) == 0);
            drive(vld, lst, {dat[3], dat[2], dat[1], dat[0]}, f, af);
            if (owner < 0) begin
                ew = 0; er = '0; ed = '0; eb = 0;
            end else begin
                ew = vld[owner] && !f;
                er = ew ? (4'b0001 << owner) : 4'b0000;
                ed = dat[owner];
                eb = 1;
            end
            #2;
            check("rnd_winc", winc, ew);
            check("rnd_ready", req_ready, er);
            check("rnd_wdata", wdata, ed);
            check("rnd_busy", busy, eb);
            check("rnd_gid", grant_id, gid);
            @(posedge wclk);
            #1;
            if (owner < 0) begin
                if (vld != 0 && !f && !af) begin
                    owner = first_from(plast, vld);
                    gid = owner;
                    taken = 0;
                end
            end else if (ew) begin
                taken++;
                seq[owner] = seq[owner] + 8'd1;
                vld[owner] = 1'b0;
                if (lst[owner] || taken == 4) begin
                    plast = owner;
                    owner = -1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO (`fifo_top` write side) between NUM_REQ requesters.
- Lives entirely in the wclk domain. Drives the FIFO's wdata/winc and consumes its wfull/walmost_full.
- Grants are burst-locked: a winner keeps the port until its last beat or until MAX_BURST beats, so packets stay contiguous in the FIFO.

Parameters:
- DATASIZE, 8, FIFO data width.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum beats per grant (>=1).
- AFULL_GATE, 1, when 1 no new grant is issued while walmost_full=1.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_last  in  NUM_REQ  per-requester last beat of packet.
- req_data  in  NUM_REQ*DATASIZE  requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_ready  out  NUM_REQ  beat accepted (one-hot or zero).
- wdata  out  DATASIZE  to FIFO wdata.
- winc  out  1  to FIFO winc.
- wfull  in  1  FIFO full.
- walmost_full  in  1  FIFO almost full.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  high in state BURST.

Behaviour:
- FSM states are IDLE and BURST. Registers: state, grant_id, last_grant, beat_cnt (width $clog2(MAX_BURST)).
- Reset (async, any time including mid-burst):
  - state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0.
  - Combinational outputs then evaluate to winc=0, req_ready=0, busy=0, wdata=0.
- IDLE:
  - Grant condition: any req_valid, AND wfull=0, AND (AFULL_GATE=0 or walmost_full=0).
  - Winner: the first valid requester searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - At that clock edge: grant_id<=winner, beat_cnt<=0, state<=BURST.
  - Arbitration costs exactly one cycle. No data moves in IDLE.
- BURST (combinational outputs):
  - winc = req_valid[grant_id] & ~wfull.
  - req_ready[grant_id] = winc; all other req_ready bits are 0.
  - wdata = req_data slice of grant_id, whether or not winc is high.
- BURST (accepted beat, winc=1):
  - If req_last[grant_id]=1 or beat_cnt==MAX_BURST-1: state<=IDLE, last_grant<=grant_id.
  - Otherwise beat_cnt<=beat_cnt+1.
- BURST stalls:
  - wfull=1, or the granted requester drops req_valid: hold state and beat_cnt, winc=0. No timeout.
  - walmost_full does not interrupt a burst in progress.
- Back-to-back bursts: return to IDLE costs one bubble cycle. Throughput is at most MAX_BURST beats per MAX_BURST+1 cycles.
- Non-granted requesters are never acknowledged. Their req_valid/req_data must be held stable until req_ready.
- Full boundary: the FIFO's wfull is registered in wclk, so winc must be gated combinationally by the live wfull. A beat is never presented to the FIFO with wfull=1.
- grant_id remains valid in IDLE and shows the last winner.

Test Plan:
- Single requester, packet of 3: req_valid[0]=1, data 0x10,0x11,0x12, req_last on 0x12.
  -> grant at edge 1; winc high cycles 2-4 with wdata 0x10/0x11/0x12; IDLE at edge 4; last_grant=0.
- Fairness: all four requesters send continuous 1-beat packets (req_last=1).
  -> grant order 0,1,2,3,0,1…; one write every 2 cycles; no requester skipped.
- Burst cap: requester 2 sends 6 beats with no req_last, MAX_BURST=4, requester 3 also valid.
  -> 4 beats from 2, then grant to 3, then grant back to 2 for its remaining 2 beats.
- Full stall: force wfull=1 for 5 cycles mid-burst after beat 1.
  -> winc=0 and req_ready=0 during the stall; beat_cnt holds; beats 2..n resume with no loss or duplication.
  -> FIFO read-side check: data order is contiguous.
- Almost-full gating: walmost_full=1 in IDLE with AFULL_GATE=1.
  -> no grant issued; grant occurs the cycle after walmost_full falls.
  -> with AFULL_GATE=0 the same stimulus produces an immediate grant.
- Reset mid-burst: assert wrst_n=0 asynchronously after beat 2 of 4.
  -> winc, req_ready, busy go 0 immediately.
  -> after release, requester 0 wins first; there are no spurious writes.
